// File: rtl/mastermind_if.sv
// Player-side bus of the Mastermind scoring core: entry strobes in, score and status out.
interface mastermind_if #(
  parameter int PEGS        = 4,
  parameter int COLOR_W     = 3,
  parameter int MAX_GUESSES = 8
);
  localparam int CNT_W = $clog2(PEGS + 1);
  localparam int GC_W  = $clog2(MAX_GUESSES + 1);

  logic                     load;
  logic [COLOR_W-1:0]       data_in;
  logic                     new_game;
  logic [PEGS*COLOR_W-1:0]  code_out;
  logic [PEGS*COLOR_W-1:0]  guess_out;
  logic [CNT_W-1:0]         red;
  logic [CNT_W-1:0]         white;
  logic                     result_valid;
  logic [GC_W-1:0]          guess_count;
  logic                     win;
  logic                     lose;
  logic                     busy;

  modport master (
    output load, data_in, new_game,
    input  code_out, guess_out, red, white, result_valid, guess_count, win, lose, busy
  );

  modport slave (
    input  load, data_in, new_game,
    output code_out, guess_out, red, white, result_valid, guess_count, win, lose, busy
  );
endinterface

// File: rtl/mastermind_core.sv
// Mastermind code/guess entry and serial red/white scoring engine.
// Optional: define MASTERMIND_CODE_REVEAL_EN to show the stored code on code_out at all times.
//
// state       | meaning
// ------------+-------------------------------------------------
// LOAD_CODE   | capturing secret pegs, one per load
// LOAD_GUESS  | capturing guess pegs, one per load
// SCORE_RED   | latch exact-match vector and red count
// SCORE_WHITE | PEGS cycles, one code peg matched per cycle
// RESULT      | publish score, bump guess count, decide outcome
// DONE        | game won or lost, waiting for new_game
module mastermind_core #(
  parameter int PEGS        = 4,
  parameter int COLOR_W     = 3,
  parameter int MAX_GUESSES = 8
) (
  input logic         clk,
  input logic         resetn,
  mastermind_if.slave mm
);
  localparam int CNT_W = $clog2(PEGS + 1);
  localparam int GC_W  = $clog2(MAX_GUESSES + 1);
  localparam int IDX_W = $clog2(PEGS);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PEGS - 1);
  localparam logic [CNT_W-1:0] ALL_RED   = CNT_W'(PEGS);
  localparam logic [GC_W-1:0]  GC_LIMIT  = GC_W'(MAX_GUESSES);

  typedef enum logic [2:0] {
    LOAD_CODE,
    LOAD_GUESS,
    SCORE_RED,
    SCORE_WHITE,
    RESULT,
    DONE
  } state_t;

  state_t                        state;
  logic [IDX_W-1:0]              idx;
  logic [PEGS-1:0][COLOR_W-1:0]  code_r;
  logic [PEGS-1:0][COLOR_W-1:0]  guess_r;
  logic [PEGS-1:0]               exact_r;
  logic [PEGS-1:0]               used_r;
  logic [CNT_W-1:0]              red_acc;
  logic [CNT_W-1:0]              white_acc;
  logic [CNT_W-1:0]              red_r;
  logic [CNT_W-1:0]              white_r;
  logic [GC_W-1:0]               gc_r;
  logic                          result_valid_r;
  logic                          win_r;
  logic                          lose_r;
  logic                          busy_r;

  logic [PEGS-1:0]               exact_c;
  logic                          match_found;
  logic [IDX_W-1:0]              match_idx;
  logic [GC_W-1:0]               gc_next;

  function automatic logic [CNT_W-1:0] popcount(input logic [PEGS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < PEGS; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  always_comb begin
    exact_c = '0;
    for (int i = 0; i < PEGS; i++) exact_c[i] = (code_r[i] == guess_r[i]);
  end

  // Descending scan so the lowest eligible guess peg wins.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int j = PEGS - 1; j >= 0; j--) begin
      if (!exact_r[j] && !used_r[j] && (guess_r[j] == code_r[idx])) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(j);
      end
    end
  end

  assign gc_next = (gc_r == GC_LIMIT) ? gc_r : gc_r + GC_W'(1);

  always_ff @(posedge clk) begin
    result_valid_r <= 1'b0;
    if (!resetn) begin
      state     <= LOAD_CODE;
      idx       <= '0;
      code_r    <= '0;
      guess_r   <= '0;
      exact_r   <= '0;
      used_r    <= '0;
      red_acc   <= '0;
      white_acc <= '0;
      red_r     <= '0;
      white_r   <= '0;
      gc_r      <= '0;
      win_r     <= 1'b0;
      lose_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else if (mm.new_game) begin
      state     <= LOAD_CODE;
      idx       <= '0;
      code_r    <= '0;
      guess_r   <= '0;
      red_r     <= '0;
      white_r   <= '0;
      gc_r      <= '0;
      win_r     <= 1'b0;
      lose_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state)
        LOAD_CODE: begin
          if (mm.load) begin
            code_r[idx] <= mm.data_in;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= LOAD_GUESS;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        LOAD_GUESS: begin
          if (mm.load) begin
            guess_r[idx] <= mm.data_in;
            if (idx == LAST_IDX) begin
              idx    <= '0;
              busy_r <= 1'b1;
              state  <= SCORE_RED;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        SCORE_RED: begin
          exact_r   <= exact_c;
          red_acc   <= popcount(exact_c);
          white_acc <= '0;
          used_r    <= '0;
          idx       <= '0;
          state     <= SCORE_WHITE;
        end
        SCORE_WHITE: begin
          if (!exact_r[idx] && match_found) begin
            used_r[match_idx] <= 1'b1;
            white_acc         <= white_acc + CNT_W'(1);
          end
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= RESULT;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        RESULT: begin
          red_r          <= red_acc;
          white_r        <= white_acc;
          result_valid_r <= 1'b1;
          gc_r           <= gc_next;
          busy_r         <= 1'b0;
          if (red_acc == ALL_RED) begin
            win_r <= 1'b1;
            state <= DONE;
          end else if (gc_next == GC_LIMIT) begin
            lose_r <= 1'b1;
            state  <= DONE;
          end else begin
            state <= LOAD_GUESS;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= LOAD_CODE;
      endcase
    end
  end

`ifdef MASTERMIND_CODE_REVEAL_EN
  assign mm.code_out = code_r;
`else
  assign mm.code_out = (state == DONE) ? code_r : '0;
`endif

  assign mm.guess_out    = guess_r;
  assign mm.red          = red_r;
  assign mm.white        = white_r;
  assign mm.result_valid = result_valid_r;
  assign mm.guess_count  = gc_r;
  assign mm.win          = win_r;
  assign mm.lose         = lose_r;
  assign mm.busy         = busy_r;
endmodule
